// File: rtl/rom_uploader.sv
// rom_uploader: responder side of the host ioctl upload path.
// Serves single-word host reads from the 8-bit internal ROM.
// The returned 16-bit word puts the lower ROM byte in the high half, which
// mirrors the download path's byte flip. An uploaded image is therefore
// byte-identical to the file that was downloaded.
// The ROM read port is shared with the CPU. mem_busy refuses a request in
// any cycle the CPU owns the port, and the FSM holds until the port is free.
module rom_uploader #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          MEM_SIZE   = 4096,
  parameter logic [15:0] FILL_WORD  = 16'hFFFF
) (
  input  logic                  clk_sys_131_072,
  input  logic                  reset,
  input  logic                  ioctl_upload,
  input  logic                  ioctl_rd,
  input  logic [24:0]           ioctl_addr,
  output logic [15:0]           ioctl_din,
  output logic                  ioctl_wait,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  input  logic                  mem_busy,
  output logic                  rd_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    CAP_LO,
    DONE
  } state_t;

  // The range check uses the full host address, so words above the ROM
  // report FILL_WORD and do not alias into it.
  localparam logic [24:0] MEM_LIMIT = 25'(MEM_SIZE);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            hi_q, hi_d;
  logic                  hi_valid_q, hi_valid_d;
  logic                  upload_q;

  logic [15:0]           din_d;
  logic                  wait_d;
  logic                  mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  overrun_d;
  logic [24:0]           req_addr;
  logic                  unused_addr_lsb;

  // The host addresses words, so bit 0 of its byte address carries no meaning.
  assign unused_addr_lsb = ioctl_addr[0];
  assign req_addr        = {ioctl_addr[24:1], 1'b0};

  // Register the state and every output, so that nothing combinational reaches a port.
  always_ff @(posedge clk_sys_131_072) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      hi_q       <= '0;
      hi_valid_q <= 1'b0;
      upload_q   <= 1'b0;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      rd_overrun <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      hi_valid_q <= hi_valid_d;
      upload_q   <= ioctl_upload;
      ioctl_din  <= din_d;
      ioctl_wait <= wait_d;
      mem_rd     <= mem_rd_d;
      mem_addr   <= mem_addr_d;
      rd_overrun <= overrun_d;
    end
  end

  // Next-state and next-output logic. Each register holds its value unless a
  // state says otherwise.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    hi_valid_d = hi_valid_q;
    din_d      = ioctl_din;
    wait_d     = ioctl_wait;
    mem_rd_d   = mem_rd;
    mem_addr_d = mem_addr;
    overrun_d  = rd_overrun;

    // A new session starts with a clean overrun flag. A pulse that arrives
    // while a word is in flight is dropped but recorded. The overrun set has
    // priority over the session clear.
    if (ioctl_upload && !upload_q) begin
      overrun_d = 1'b0;
    end
    if ((state_q != IDLE) && ioctl_upload && ioctl_rd) begin
      overrun_d = 1'b1;
    end

    if ((state_q != IDLE) && !ioctl_upload) begin
      // The session has closed under us. Release the ROM port and the host,
      // and keep the last delivered word.
      state_d  = IDLE;
      mem_rd_d = 1'b0;
      wait_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ioctl_upload && ioctl_rd) begin
            wait_d = 1'b1;
            addr_d = req_addr[ADDR_WIDTH-1:0];
            if (req_addr >= MEM_LIMIT) begin
              state_d = DONE;
            end else begin
              state_d    = REQ_HI;
              mem_rd_d   = 1'b1;
              mem_addr_d = req_addr[ADDR_WIDTH-1:0];
            end
          end
        end

        REQ_HI: begin
          if (!mem_busy) begin
            state_d    = REQ_LO;
            hi_valid_d = 1'b0;
            mem_addr_d = {addr_q[ADDR_WIDTH-1:1], 1'b1};
          end
        end

        REQ_LO: begin
          // The high byte is valid only on the first cycle after its
          // request was accepted. Later stall cycles carry CPU data.
          if (!hi_valid_q) begin
            hi_d       = mem_data;
            hi_valid_d = 1'b1;
          end
          if (!mem_busy) begin
            state_d  = CAP_LO;
            mem_rd_d = 1'b0;
          end
        end

        CAP_LO: begin
          din_d   = {hi_q, mem_data};
          wait_d  = 1'b0;
          state_d = IDLE;
        end

        DONE: begin
          din_d   = FILL_WORD;
          wait_d  = 1'b0;
          state_d = IDLE;
        end

        default: begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          wait_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_uploader.md
Name: rom_uploader

Overview:
- Responder side of the host ioctl upload path: serves host read requests by reading the 8-bit internal ROM and returning 16-bit words on the ioctl bus.
- Mirrors the download path's byte flip, so an uploaded image is byte-identical to the downloaded file.
- Sits beside rom_loader at the top level.
- Shares the ROM read port with the CPU fetch through a busy/stall interface.

Parameters:
- ADDR_WIDTH, 12, ROM byte address width.
- MEM_SIZE, 4096, number of valid ROM bytes. Must be even and no larger than 2^ADDR_WIDTH.
- FILL_WORD, 16'hFFFF, value returned for out-of-range words.

Ports:
- clk_sys_131_072  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  host upload session active.
- ioctl_rd  in  1  single-cycle read request pulse from the host.
- ioctl_addr  in  25  byte address of the requested word; bit 0 ignored.
- ioctl_din  out  16  returned word.
- ioctl_wait  out  1  high while a request is in flight; host samples ioctl_din only while low.
- mem_rd  out  1  ROM read request.
- mem_addr  out  ADDR_WIDTH  ROM byte address.
- mem_data  in  8  ROM read data, valid the cycle after an accepted request.
- mem_busy  in  1  port owned by CPU this cycle; the request presented this cycle is not accepted.
- rd_overrun  out  1  sticky: an ioctl_rd arrived while not IDLE.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, mem_rd=0, mem_addr=0, rd_overrun=0, state=IDLE.
- All outputs are registered.
- Acceptance and addressing:
  - A request is accepted only in IDLE, with ioctl_upload=1 and ioctl_rd=1.
  - On acceptance, latch A={ioctl_addr[24:1],1'b0} and set ioctl_wait=1.
- States and transitions:
  - IDLE: if A >= MEM_SIZE, go to DONE with no memory access; else go to REQ_HI.
  - REQ_HI: drive mem_rd=1, mem_addr=A. If mem_busy=0 this cycle, the request is accepted and the next state is REQ_LO; else hold.
  - REQ_LO: on the first cycle in this state, capture hi=mem_data. Drive mem_addr=A+1. On mem_busy=0, go to CAP_LO; else hold, and do not re-capture hi.
  - CAP_LO: mem_rd=0. Capture lo=mem_data, load ioctl_din={hi,lo}, clear ioctl_wait, go to IDLE.
  - DONE (out of range): ioctl_din=FILL_WORD, ioctl_wait=0, go to IDLE.
- Byte order: ioctl_din[15:8]=ROM[A], ioctl_din[7:0]=ROM[A+1].
- Latency with no stall: request pulse sampled at edge 0; ioctl_wait visible from edge 0; ioctl_din valid and ioctl_wait low after edge 3. Each mem_busy cycle adds one cycle.
- Out-of-range latency: ioctl_din valid and ioctl_wait low after edge 1.
- ioctl_din holds its value between requests.
- ioctl_rd while not IDLE: the pulse is ignored and rd_overrun is set. rd_overrun clears only on reset or at the start of a new session (rising edge of ioctl_upload).
- ioctl_upload falling mid-request: abort to IDLE on the next edge. mem_rd=0, ioctl_wait=0, ioctl_din unchanged.
- ioctl_rd with ioctl_upload=0: ignored, rd_overrun not set.
- Reset mid-request: all registers return to reset values on that edge.
- Address arithmetic: A+1 never exceeds MEM_SIZE-1, because MEM_SIZE is even. Upper address bits beyond ADDR_WIDTH participate in the range check only.

Test Plan:
- Preload ROM[0x10]=0xAB, ROM[0x11]=0xCD; ioctl_upload=1; pulse ioctl_rd with addr 0x10 → ioctl_wait high 3 cycles, then ioctl_din=0xABCD, ioctl_wait=0; mem_addr sequence 0x10, 0x11.
- Same request with addr 0x11 (odd) → identical result 0xABCD.
- Same request with mem_busy high for 2 cycles during REQ_HI and 1 cycle during REQ_LO → ioctl_din=0xABCD after 6 cycles; hi byte not corrupted by the stall.
- Request at addr 0x1000 with MEM_SIZE=4096 → no mem_rd asserted; ioctl_din=0xFFFF after 1 cycle.
- Second ioctl_rd pulse one cycle after the first → first word completes normally; rd_overrun=1. Toggling ioctl_upload low then high clears it.
- Drop ioctl_upload during REQ_LO → next cycle state=IDLE, ioctl_wait=0, mem_rd=0, ioctl_din retains its previous word. Repeat the scenario with reset instead → all outputs 0.
